// File: rtl/uart_stream_checker.sv
// UART receive-and-compare engine: deframes characters from rx and checks them
// against an expected message held in a small internal RAM.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start
// S_ARMED | waiting for a falling edge on rx, timeout counter running
// S_START | half-bit wait, then confirm the start bit or reject a glitch
// S_DATA  | DATA_BITS samples, LSB first, DIV cycles apart
// S_PAR   | parity sample (only reached when PARITY != 0)
// S_STOP  | STOP_BITS samples, verdict registered on the last one
// S_CHECK | rx_valid pulse; continue or finish
// S_DONE  | drop busy, back to idle
module uart_stream_checker #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int MAX_LEN     = 64,
    parameter int TIMEOUT_CYC = 1_000_000,
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 exp_we,
    input  logic [AW-1:0]        exp_addr,
    input  logic [DATA_BITS-1:0] exp_data,
    input  logic [AW:0]          msg_len,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic [2:0]           fail_code,
    output logic [AW:0]          byte_idx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid
);
    localparam int DIV  = CLK_FREQ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW   = $clog2(TIMEOUT_CYC + 1);
    localparam int IW   = AW + 1;
    localparam int BW   = 4;
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'((HALF > 0) ? HALF - 1 : 0);
    localparam logic [TW-1:0] TO_M1   = TW'(TIMEOUT_CYC - 1);
    localparam logic [BW-1:0] DB_M1   = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] SB_M1   = BW'(STOP_BITS - 1);
    localparam logic          PAR_ODD = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_START, S_DATA, S_PAR, S_STOP, S_CHECK, S_DONE
    } state_t;

    state_t               state_q;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    logic [CW-1:0]        cnt_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [TW-1:0]        to_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 frm_q;
    logic [IW-1:0]        len_q;
    logic                 busy_q, done_q, pass_q, fail_q, rx_valid_q;
    logic [2:0]           fail_code_q;
    logic [IW-1:0]        byte_idx_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic [DATA_BITS-1:0] exp_q;
    logic [DATA_BITS-1:0] mem [MAX_LEN];

    logic                 rx_bit, fall;
    logic                 frm_err, par_err, mis_err;
    logic [IW-1:0]        idx_inc;
    logic [TW-1:0]        to_dec;

    assign rx_bit  = rx_s2_q;
    assign fall    = rx_prev_q & ~rx_s2_q;
    assign frm_err = frm_q | ~rx_bit;
    assign par_err = (PARITY != 0) && ((^shift_q ^ par_q) != PAR_ODD);
    assign mis_err = (shift_q != exp_q);
    assign idx_inc = byte_idx_q + IW'(1);
    assign to_dec  = (to_cnt_q == '0) ? '0 : to_cnt_q - TW'(1);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // byte_idx is stable long before CHECK, so a free-running read is a valid prefetch.
    always_ff @(posedge clk) begin
        if (exp_we && !busy_q)
            mem[exp_addr] <= exp_data;
        exp_q <= mem[byte_idx_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            to_cnt_q    <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            frm_q       <= 1'b0;
            len_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_code_q <= '0;
            byte_idx_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        fail_q      <= 1'b0;
                        fail_code_q <= '0;
                        byte_idx_q  <= '0;
                        len_q       <= msg_len;
                        to_cnt_q    <= TO_M1;
                        if (msg_len == '0) begin
                            done_q <= 1'b1;
                            pass_q <= 1'b1;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= S_ARMED;
                        end
                    end
                end
                S_ARMED: begin
                    if (fall) begin
                        to_cnt_q <= to_dec;
                        cnt_q    <= HALF_M1;
                        state_q  <= S_START;
                    end else if (to_cnt_q == '0) begin
                        fail_q      <= 1'b1;
                        done_q      <= 1'b1;
                        fail_code_q <= 3'd4;
                        state_q     <= S_DONE;
                    end else begin
                        to_cnt_q <= to_dec;
                    end
                end
                S_START: begin
                    // A rejected glitch keeps the timeout counter running.
                    if (cnt_q == '0) begin
                        if (rx_bit) begin
                            to_cnt_q <= to_dec;
                            state_q  <= S_ARMED;
                        end else begin
                            to_cnt_q  <= TO_M1;
                            cnt_q     <= DIV_M1;
                            bit_cnt_q <= '0;
                            frm_q     <= 1'b0;
                            state_q   <= S_DATA;
                        end
                    end else begin
                        to_cnt_q <= to_dec;
                        cnt_q    <= cnt_q - CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == '0) begin
                        shift_q <= {rx_bit, shift_q[DATA_BITS-1:1]};
                        cnt_q   <= DIV_M1;
                        if (bit_cnt_q == DB_M1) begin
                            bit_cnt_q <= '0;
                            state_q   <= (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_PAR: begin
                    if (cnt_q == '0) begin
                        par_q   <= rx_bit;
                        cnt_q   <= DIV_M1;
                        state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_q == '0) begin
                        if (bit_cnt_q == SB_M1) begin
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                            state_q    <= S_CHECK;
                            if (frm_err || par_err || mis_err) begin
                                fail_q      <= 1'b1;
                                done_q      <= 1'b1;
                                fail_code_q <= frm_err ? 3'd1 : (par_err ? 3'd2 : 3'd3);
                            end else begin
                                byte_idx_q <= idx_inc;
                                if (idx_inc == len_q) begin
                                    pass_q <= 1'b1;
                                    done_q <= 1'b1;
                                end
                            end
                        end else begin
                            frm_q     <= frm_err;
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                            cnt_q     <= DIV_M1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_CHECK: begin
                    state_q <= done_q ? S_DONE : S_ARMED;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_code = fail_code_q;
    assign byte_idx  = byte_idx_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;

endmodule

// File: tb/tb_uart_stream_checker.sv
// Directed bench for uart_stream_checker: four instances cover 8N1, 8N2, 7O1
// and the default 434-cycle bit time with a short timeout.
module tb_uart_stream_checker;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_line = 1'b1;
    logic       exp_we = 1'b0;
    logic [5:0] exp_addr = '0;
    logic [7:0] exp_data = '0;
    logic [6:0] msg_len = '0;
    logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0, start_d = 1'b0;

    logic       a_busy, a_done, a_pass, a_fail, a_rx_valid;
    logic [2:0] a_code;
    logic [6:0] a_idx;
    logic [7:0] a_rx_data;
    logic       b_busy, b_done, b_pass, b_fail, b_rx_valid;
    logic [2:0] b_code;
    logic [6:0] b_idx;
    logic [7:0] b_rx_data;
    logic       c_busy, c_done, c_pass, c_fail, c_rx_valid;
    logic [2:0] c_code;
    logic [6:0] c_idx;
    logic [6:0] c_rx_data;
    logic       d_busy, d_done, d_pass, d_fail, d_rx_valid;
    logic [2:0] d_code;
    logic [6:0] d_idx;
    logic [7:0] d_rx_data;

    int n_cmp = 0;
    int n_mis = 0;
    int va = 0, vb = 0, vc = 0, vd = 0;
    int base;

    logic [7:0] msg [13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                             8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (a_rx_valid) va <= va + 1;
        if (b_rx_valid) vb <= vb + 1;
        if (c_rx_valid) vc <= vc + 1;
        if (d_rx_valid) vd <= vd + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // DIV = 16 for the three fast instances.
    uart_stream_checker #(.CLK_FREQ(1_843_200)) u_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_line), .exp_we(exp_we), .exp_addr(exp_addr),
        .exp_data(exp_data), .msg_len(msg_len), .start(start_a), .busy(a_busy),
        .done(a_done), .pass(a_pass), .fail(a_fail), .fail_code(a_code),
        .byte_idx(a_idx), .rx_data(a_rx_data), .rx_valid(a_rx_valid));

    uart_stream_checker #(.CLK_FREQ(1_843_200), .STOP_BITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_line), .exp_we(exp_we), .exp_addr(exp_addr),
        .exp_data(exp_data), .msg_len(msg_len), .start(start_b), .busy(b_busy),
        .done(b_done), .pass(b_pass), .fail(b_fail), .fail_code(b_code),
        .byte_idx(b_idx), .rx_data(b_rx_data), .rx_valid(b_rx_valid));

    uart_stream_checker #(.CLK_FREQ(1_843_200), .DATA_BITS(7), .PARITY(2)) u_c (
        .clk(clk), .rst_n(rst_n), .rx(rx_line), .exp_we(exp_we), .exp_addr(exp_addr),
        .exp_data(exp_data[6:0]), .msg_len(msg_len), .start(start_c), .busy(c_busy),
        .done(c_done), .pass(c_pass), .fail(c_fail), .fail_code(c_code),
        .byte_idx(c_idx), .rx_data(c_rx_data), .rx_valid(c_rx_valid));

    uart_stream_checker #(.TIMEOUT_CYC(5000)) u_d (
        .clk(clk), .rst_n(rst_n), .rx(rx_line), .exp_we(exp_we), .exp_addr(exp_addr),
        .exp_data(exp_data), .msg_len(msg_len), .start(start_d), .busy(d_busy),
        .done(d_done), .pass(d_pass), .fail(d_fail), .fail_code(d_code),
        .byte_idx(d_idx), .rx_data(d_rx_data), .rx_valid(d_rx_valid));

    task automatic arm(input int w, input logic [6:0] len);
        msg_len = len;
        case (w)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
            2: start_c = 1'b1;
            default: start_d = 1'b1;
        endcase
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        start_d = 1'b0;
    endtask

    // rst_bit >= 0 pulses the reset during that data bit and checks u_a is cleared.
    task automatic send_char(input logic [8:0] d, input int nbits, input int div,
                             input int par_en, input logic par_b, input logic stop1,
                             input logic stop2, input int nstop, input int rst_bit);
        rx_line = 1'b0;
        repeat (div) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rx_line = d[i];
            if (i == rst_bit) begin
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                chk("reset_mid_frame", {a_busy, a_done, a_pass, a_fail, a_code, a_idx, a_rx_data, a_rx_valid}, 23'd0);
                rst_n = 1'b0;
                repeat (div - 3) @(negedge clk);
            end else begin
                repeat (div) @(negedge clk);
            end
        end
        if (par_en != 0) begin
            rx_line = par_b;
            repeat (div) @(negedge clk);
        end
        rx_line = stop1;
        repeat (div) @(negedge clk);
        if (nstop == 2) begin
            rx_line = stop2;
            repeat (div) @(negedge clk);
        end
        rx_line = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send8(input logic [7:0] d);
        send_char({1'b0, d}, 8, 16, 0, 1'b0, 1'b1, 1'b1, 1, -1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_a", {a_busy, a_done, a_pass, a_fail, a_code, a_idx, a_rx_data, a_rx_valid}, 23'd0);
        chk("reset_b", {b_busy, b_done, b_pass, b_fail, b_code, b_idx, b_rx_data, b_rx_valid}, 23'd0);
        chk("reset_c", {c_busy, c_done, c_pass, c_fail, c_code, c_idx, c_rx_data, c_rx_valid}, 22'd0);
        chk("reset_d", {d_busy, d_done, d_pass, d_fail, d_code, d_idx, d_rx_data, d_rx_valid}, 23'd0);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);

        // Write and start in the same cycle; the new word must be checked.
        exp_we = 1'b1; exp_addr = 6'd0; exp_data = 8'h5A; msg_len = 7'd1; start_a = 1'b1;
        @(negedge clk);
        exp_we = 1'b0; start_a = 1'b0;
        chk("we_start_busy", a_busy, 1'b1);
        send8(8'h5A);
        repeat (4) @(negedge clk);
        chk("we_start_pass", a_pass, 1'b1);
        chk("we_start_rx_data", a_rx_data, 8'h5A);

        for (int i = 0; i < 13; i++) begin
            exp_we = 1'b1; exp_addr = 6'(i); exp_data = msg[i];
            @(negedge clk);
        end
        exp_we = 1'b0;

        arm(0, 7'd0);
        chk("len0_done", a_done, 1'b1);
        chk("len0_pass", a_pass, 1'b1);
        chk("len0_busy", a_busy, 1'b0);

        base = va;
        arm(0, 7'd13);
        for (int i = 0; i < 13; i++) send8(msg[i]);
        repeat (4) @(negedge clk);
        chk("pass_valid_count", va - base, 13);
        chk("pass_flags", {a_pass, a_done, a_fail, a_busy}, 4'b1100);
        chk("pass_code", a_code, 3'd0);
        chk("pass_idx", a_idx, 7'd13);
        chk("pass_rx_data", a_rx_data, 8'h0A);

        base = va;
        arm(0, 7'd13);
        arm(0, 7'd0);
        chk("start_while_busy", {a_busy, a_done}, 2'b10);
        for (int i = 0; i < 4; i++) send8(msg[i]);
        send8(8'h78);
        repeat (4) @(negedge clk);
        chk("mis_flags", {a_fail, a_done, a_pass, a_busy}, 4'b1100);
        chk("mis_code", a_code, 3'd3);
        chk("mis_idx", a_idx, 7'd4);
        chk("mis_rx_data", a_rx_data, 8'h78);
        chk("mis_valid_count", va - base, 5);
        send8(msg[5]);
        send8(msg[6]);
        chk("mis_no_more_valid", va - base, 5);

        arm(0, 7'd13);
        send_char(9'h048, 8, 16, 0, 1'b0, 1'b0, 1'b1, 1, -1);
        repeat (4) @(negedge clk);
        chk("frm_code", a_code, 3'd1);
        chk("frm_idx", a_idx, 7'd0);
        chk("frm_flags", {a_fail, a_done}, 2'b11);

        arm(0, 7'd13);
        send8(msg[0]);
        send8(msg[1]);
        send_char({1'b0, msg[2]}, 8, 16, 0, 1'b0, 1'b1, 1'b1, 1, 3);
        repeat (4) @(negedge clk);
        chk("after_reset", {a_busy, a_done, a_pass, a_fail, a_code, a_idx, a_rx_data, a_rx_valid}, 23'd0);
        arm(0, 7'd13);
        for (int i = 0; i < 13; i++) send8(msg[i]);
        repeat (4) @(negedge clk);
        chk("restart_pass", {a_pass, a_done, a_fail, a_busy}, 4'b1100);
        chk("restart_idx", a_idx, 7'd13);

        base = vb;
        arm(1, 7'd1);
        send_char(9'h048, 8, 16, 0, 1'b0, 1'b1, 1'b1, 2, -1);
        repeat (4) @(negedge clk);
        chk("stop2_pass", {b_pass, b_fail, b_busy}, 3'b100);
        chk("stop2_rx_data", b_rx_data, 8'h48);
        chk("stop2_valid_count", vb - base, 1);
        arm(1, 7'd1);
        send_char(9'h048, 8, 16, 0, 1'b0, 1'b1, 1'b0, 2, -1);
        repeat (4) @(negedge clk);
        chk("stop2_frm_code", b_code, 3'd1);
        chk("stop2_frm_idx", b_idx, 7'd0);
        chk("stop2_frm_done", {b_done, b_fail}, 2'b11);

        // 0x48 in 7 bits has two ones, so odd parity needs a 1.
        base = vc;
        arm(2, 7'd1);
        send_char(9'h048, 7, 16, 1, 1'b0, 1'b1, 1'b1, 1, -1);
        repeat (4) @(negedge clk);
        chk("par_bad_code", c_code, 3'd2);
        chk("par_bad_idx", c_idx, 7'd0);
        chk("par_bad_flags", {c_fail, c_done, c_busy}, 3'b110);
        arm(2, 7'd1);
        send_char(9'h048, 7, 16, 1, 1'b1, 1'b1, 1'b1, 1, -1);
        repeat (4) @(negedge clk);
        chk("par_ok_pass", {c_pass, c_fail}, 2'b10);
        chk("par_ok_code", c_code, 3'd0);
        chk("par_ok_rx_data", c_rx_data, 7'h48);
        arm(2, 7'd1);
        send_char(9'h048, 7, 16, 1, 1'b0, 1'b0, 1'b1, 1, -1);
        repeat (4) @(negedge clk);
        chk("frm_over_par_code", c_code, 3'd1);
        chk("par_valid_count", vc - base, 3);

        arm(3, 7'd1);
        send_char(9'h048, 8, 434, 0, 1'b0, 1'b1, 1'b1, 1, -1);
        repeat (4) @(negedge clk);
        chk("div434_pass", {d_pass, d_fail, d_busy}, 3'b100);
        chk("div434_rx_data", d_rx_data, 8'h48);
        chk("div434_idx", d_idx, 7'd1);

        base = vd;
        msg_len = 7'd1;
        start_d = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_d = 1'b0;
        repeat (200) @(posedge clk);
        @(negedge clk);
        rx_line = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        rx_line = 1'b1;
        repeat (4699) @(posedge clk);
        #1;
        chk("timeout_not_early", d_fail, 1'b0);
        @(posedge clk);
        #1;
        chk("timeout_fail", {d_fail, d_done}, 2'b11);
        chk("timeout_code", d_code, 3'd4);
        @(negedge clk);
        chk("glitch_no_valid", vd - base, 0);
        chk("timeout_idx", d_idx, 7'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
